// File: rtl/draw_cmd_writer_pkg.sv
// Shared constants for the draw-command writer: frame size, command word layout
// and FSM state encoding.
package draw_cmd_writer_pkg;

    localparam int DEF_WIDTH  = 160;
    localparam int DEF_HEIGHT = 120;

    localparam int SWAP_BIT  = 15;
    localparam int LINE_MSB  = 14;
    localparam int LINE_LSB  = 8;
    localparam int LEFT_MSB  = 7;
    localparam int LEFT_LSB  = 0;
    localparam int RIGHT_MSB = 7;
    localparam int RIGHT_LSB = 0;
    localparam int COLOR_MSB = 15;
    localparam int COLOR_LSB = 13;

    localparam logic [15:0] SWAP_WORD0 = 16'h8000;
    localparam logic [15:0] SWAP_WORD1 = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2
    } state_e;

endpackage

// File: rtl/draw_cmd_writer_if.sv
// Request channel from the CPU I/O decode into the draw-command writer.
interface draw_cmd_writer_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_swap;
    logic [7:0] req_x0;
    logic [7:0] req_x1;
    logic [6:0] req_y0;
    logic [6:0] req_y1;
    logic [2:0] req_color;

    modport master (
        output req_valid, req_swap, req_x0, req_x1, req_y0, req_y1, req_color,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_swap, req_x0, req_x1, req_y0, req_y1, req_color,
        output req_ready
    );

endinterface

// File: rtl/draw_cmd_writer_span_encoder.sv
// Packs one span (or a buffer swap) into the two 16-bit command words.
module draw_span_encoder
    import draw_cmd_writer_pkg::*;
(
    input  logic        swap_i,
    input  logic [6:0]  line_i,
    input  logic [7:0]  left_i,
    input  logic [7:0]  right_i,
    input  logic [2:0]  color_i,
    output logic [15:0] word0_o,
    output logic [15:0] word1_o
);

    // Field placement for both words; swap overrides the span layout.
    always_comb begin
        word0_o = 16'h0000;
        word1_o = 16'h0000;
        if (swap_i) begin
            word0_o = SWAP_WORD0;
            word1_o = SWAP_WORD1;
        end else begin
            word0_o[SWAP_BIT]            = 1'b0;
            word0_o[LINE_MSB:LINE_LSB]   = line_i;
            word0_o[LEFT_MSB:LEFT_LSB]   = left_i;
            word1_o[COLOR_MSB:COLOR_LSB] = color_i;
            word1_o[RIGHT_MSB:RIGHT_LSB] = right_i;
        end
    end

endmodule

// File: rtl/draw_cmd_writer.sv
// Rasterises rectangle-fill / buffer-swap requests into span command word pairs
// and writes them into the draw unit's command queue, honouring its full flag.
module draw_cmd_writer
    import draw_cmd_writer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic               clk,
    input  logic               reset,
    draw_cmd_writer_if.slave   req,
    input  logic               full_i,
    output logic               we_o,
    output logic [15:0]        data_o,
    output logic               busy_o,
    output logic [15:0]        span_count_o
);

    localparam logic [7:0] XMAX = 8'(WIDTH - 1);
    localparam logic [6:0] YMAX = 7'(HEIGHT - 1);

    state_e      state_q;
    logic [6:0]  cur_line_q;
    logic [6:0]  yb_q;
    logic [7:0]  xl_q;
    logic [7:0]  xr_q;
    logic [2:0]  color_q;
    logic        swap_q;
    logic [15:0] span_count_q;

    logic [7:0]  xl_s, xr_s, xr_raw_s;
    logic [6:0]  yt_s, yb_s, yb_raw_s;
    logic        drop_s;
    logic        accept_s;
    logic [15:0] word0_s, word1_s;

    assign req.req_ready = (state_q == ST_IDLE);
    assign accept_s      = req.req_valid && req.req_ready;

    // Order the corners, clamp the far edges and flag rectangles wholly off-screen.
    always_comb begin
        xl_s     = (req.req_x0 < req.req_x1) ? req.req_x0 : req.req_x1;
        xr_raw_s = (req.req_x0 < req.req_x1) ? req.req_x1 : req.req_x0;
        yt_s     = (req.req_y0 < req.req_y1) ? req.req_y0 : req.req_y1;
        yb_raw_s = (req.req_y0 < req.req_y1) ? req.req_y1 : req.req_y0;
        xr_s     = (xr_raw_s > XMAX) ? XMAX : xr_raw_s;
        yb_s     = (yb_raw_s > YMAX) ? YMAX : yb_raw_s;
        drop_s   = (xl_s > XMAX) || (yt_s > YMAX);
    end

    draw_span_encoder u_enc (
        .swap_i  (swap_q),
        .line_i  (cur_line_q),
        .left_i  (xl_q),
        .right_i (xr_q),
        .color_i (color_q),
        .word0_o (word0_s),
        .word1_o (word1_s)
    );

    // Command FSM: latch request, walk lines, stall on full, count finished spans.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_line_q   <= 7'd0;
            yb_q         <= 7'd0;
            xl_q         <= 8'd0;
            xr_q         <= 8'd0;
            color_q      <= 3'd0;
            swap_q       <= 1'b0;
            span_count_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && req.req_swap) begin
                        swap_q  <= 1'b1;
                        state_q <= ST_W0;
                    end else if (accept_s && !drop_s) begin
                        swap_q     <= 1'b0;
                        xl_q       <= xl_s;
                        xr_q       <= xr_s;
                        cur_line_q <= yt_s;
                        yb_q       <= yb_s;
                        color_q    <= req.req_color;
                        state_q    <= ST_W0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_W0: begin
                    if (!full_i) begin
                        state_q <= ST_W1;
                    end else begin
                        state_q <= ST_W0;
                    end
                end
                ST_W1: begin
                    if (!full_i) begin
                        if (!swap_q) begin
                            span_count_q <= span_count_q + 16'd1;
                        end
                        if (swap_q || (cur_line_q == yb_q)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cur_line_q <= cur_line_q + 7'd1;
                            state_q    <= ST_W0;
                        end
                    end else begin
                        state_q <= ST_W1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The word on data_o comes straight from registered state; we is gated by
    // full in the same cycle so a word is never offered to a full queue.
    always_comb begin
        we_o   = 1'b0;
        data_o = 16'h0000;
        case (state_q)
            ST_W0: begin
                we_o   = !full_i;
                data_o = word0_s;
            end
            ST_W1: begin
                we_o   = !full_i;
                data_o = word1_s;
            end
            default: begin
                we_o   = 1'b0;
                data_o = 16'h0000;
            end
        endcase
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign span_count_o = span_count_q;

endmodule

// File: tb/tb_draw_cmd_writer.sv
// Directed self-checking bench for draw_cmd_writer with hand-computed command words.
module tb_draw_cmd_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        full;
    logic        we;
    logic [15:0] data;
    logic        busy;
    logic [15:0] span_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] cap_q[$];
    int          cap_cyc[$];

    draw_cmd_writer_if req_if ();

    draw_cmd_writer dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req_if.slave),
        .full_i       (full),
        .we_o         (we),
        .data_o       (data),
        .busy_o       (busy),
        .span_count_o (span_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every accepted word and police the no-write-while-full rule.
    always @(negedge clk) begin
        if (!reset) begin
            if (we === 1'b1) begin
                cap_q.push_back(data);
                cap_cyc.push_back(cyc);
            end
            if (full === 1'b1) chk("we_while_full", {31'd0, we}, 32'd0);
        end
    end

    task automatic clear_cap();
        cap_q.delete();
        cap_cyc.delete();
    endtask

    task automatic send_req(input logic swap, input logic [7:0] x0, input logic [7:0] x1,
                            input logic [6:0] y0, input logic [6:0] y1, input logic [2:0] color);
        int n = 0;
        while (req_if.req_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", {31'd0, req_if.req_ready}, 32'd1);
        req_if.req_valid = 1'b1;
        req_if.req_swap  = swap;
        req_if.req_x0    = x0;
        req_if.req_x1    = x1;
        req_if.req_y0    = y0;
        req_if.req_y1    = y1;
        req_if.req_color = color;
        @(posedge clk); #1;
        req_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_words(input string tag, input logic [15:0] exp[$]);
        chk({tag, "_count"}, cap_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
            chk(tag, {16'd0, cap_q[i]}, {16'd0, exp[i]});
    endtask

    initial begin
        reset            = 1'b1;
        full             = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_swap  = 1'b0;
        req_if.req_x0    = 8'd0;
        req_if.req_x1    = 8'd0;
        req_if.req_y0    = 7'd0;
        req_if.req_y1    = 7'd0;
        req_if.req_color = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_if.req_ready}, 32'd1);
        chk("rst_we",    {31'd0, we},   32'd0);
        chk("rst_data",  {16'd0, data}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_span",  {16'd0, span_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: single h-line, first word one cycle after accept
        clear_cap();
        send_req(1'b0, 8'd10, 8'd20, 7'd5, 7'd5, 3'b100);
        chk("t1_first_we",   {31'd0, we},   32'd1);
        chk("t1_first_data", {16'd0, data}, 32'h050A);
        wait_idle();
        chk_words("t1_word", '{16'h050A, 16'h8014});
        chk("t1_span", {16'd0, span_count}, 32'd1);

        // 2: swapped corners, three lines, back-to-back words
        clear_cap();
        send_req(1'b0, 8'd30, 8'd5, 7'd9, 7'd7, 3'b010);
        wait_idle();
        chk_words("t2_word", '{16'h0705, 16'h401E, 16'h0805, 16'h401E, 16'h0905, 16'h401E});
        if (cap_cyc.size() == 6) chk("t2_consecutive", cap_cyc[5] - cap_cyc[0], 32'd5);
        chk("t2_span", {16'd0, span_count}, 32'd4);
        @(posedge clk); #1;
        chk("t2_ready_after", {31'd0, req_if.req_ready}, 32'd1);

        // 3: clamp to screen edge, then a fully off-screen request
        clear_cap();
        send_req(1'b0, 8'd150, 8'd200, 7'd118, 7'd127, 3'b001);
        wait_idle();
        chk_words("t3_word", '{16'h7696, 16'h209F, 16'h7796, 16'h209F});
        chk("t3_span", {16'd0, span_count}, 32'd6);
        clear_cap();
        send_req(1'b0, 8'd170, 8'd200, 7'd118, 7'd127, 3'b001);
        chk("t3_drop_busy",  {31'd0, busy}, 32'd0);
        chk("t3_drop_ready", {31'd0, req_if.req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_drop_words", cap_q.size(), 32'd0);

        // 4: full between word0 and word1
        clear_cap();
        send_req(1'b0, 8'd1, 8'd2, 7'd3, 7'd3, 3'b111);
        @(posedge clk); #1;
        full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stall_we",   {31'd0, we},   32'd0);
            chk("t4_stall_data", {16'd0, data}, 32'hE002);
        end
        @(posedge clk); #1;
        full = 1'b0;
        wait_idle();
        chk_words("t4_word", '{16'h0301, 16'hE002});
        chk("t4_span", {16'd0, span_count}, 32'd7);

        // 5: swap accepted while full is high, emission waits
        clear_cap();
        full = 1'b1;
        send_req(1'b1, 8'd0, 8'd0, 7'd0, 7'd0, 3'd0);
        chk("t5_busy_full", {31'd0, busy}, 32'd1);
        chk("t5_we_full",   {31'd0, we},   32'd0);
        @(posedge clk); #1;
        full = 1'b0;
        wait_idle();
        chk_words("t5_word", '{16'h8000, 16'h0000});
        chk("t5_span", {16'd0, span_count}, 32'd7);

        // 6: reset in the middle of a 4-line rectangle
        clear_cap();
        send_req(1'b0, 8'd0, 8'd9, 7'd20, 7'd23, 3'b011);
        for (int n = 0; n < 50 && cap_q.size() < 3; n++) begin
            @(posedge clk); #1;
        end
        chk("t6_reached_line2", cap_q.size(), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_we",    {31'd0, we},   32'd0);
        chk("t6_busy",  {31'd0, busy}, 32'd0);
        chk("t6_ready", {31'd0, req_if.req_ready}, 32'd1);
        chk("t6_span",  {16'd0, span_count}, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_more_words", cap_q.size(), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
